// File: rtl/bus_error_log.sv
// bus_error_log
//   Captures failed-bus-transaction reports from an upstream monitor into a
//   timestamped FIFO and exposes them through a Wishbone slave register port.
//
//   Ports
//     clk, reset        system clock, synchronous active-high reset
//     err_strb          one-cycle pulse: a transaction failed
//     err_type[1:0]     error code (0 timeout, 1 nack, 2 illegal addr, 3 rsvd)
//     err_we            failed transaction was a write
//     err_addr[15:0]    address of the failed transaction
//     wb_cyc_i/stb_i/we_i, wb_adr_i[1:0], wb_dat_i[15:0]  Wishbone slave in
//     wb_dat_o[15:0], wb_ack_o                           Wishbone slave out
//     err_pending       high while the FIFO holds at least one entry
//
//   Register map (read)
//     0 status {empty, overflow, 0..., count}
//     1 head err_addr
//     2 head {ts[12:0], we, type}  -- reading pops the head entry
//     3 total-error counter (saturating)
//   Register map (write, data ignored)
//     0 clear overflow, 1 flush FIFO, 2 no effect, 3 clear total counter
module bus_error_log #(
    parameter int unsigned DEPTH_LOG2 = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        err_strb,
    input  logic [1:0]  err_type,
    input  logic        err_we,
    input  logic [15:0] err_addr,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic        wb_we_i,
    input  logic [1:0]  wb_adr_i,
    input  logic [15:0] wb_dat_i,
    output logic [15:0] wb_dat_o,
    output logic        wb_ack_o,
    output logic        err_pending
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_COUNT = (DEPTH_LOG2 + 1)'(DEPTH);

    logic [12:0]           ts;
    logic [31:0]           mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DEPTH_LOG2:0]   count;
    logic                  overflow;
    logic [15:0]           total;

    logic        wb_req;
    logic        rd_req;
    logic        wr_req;
    logic        empty;
    logic        full;
    logic        pop;
    logic        flush;
    logic        push;
    logic        drop;
    logic [31:0] head;
    logic [15:0] status;
    logic [15:0] read_data;

    // Write data carries no information for this block.
    logic unused_wb_dat;
    assign unused_wb_dat = ^wb_dat_i;

    always_comb begin
        wb_req = wb_cyc_i & wb_stb_i & ~wb_ack_o;
        rd_req = wb_req & ~wb_we_i;
        wr_req = wb_req & wb_we_i;
        empty  = (count == '0);
        full   = (count == FULL_COUNT);
        pop    = rd_req & (wb_adr_i == 2'd2) & ~empty;
        flush  = wr_req & (wb_adr_i == 2'd1);
        // A same-cycle pop or flush frees a slot, so the push is taken even when full.
        push   = err_strb & (~full | pop | flush);
        drop   = err_strb & ~push;
        head   = mem[rd_ptr];

        status                 = '0;
        status[DEPTH_LOG2:0]   = count;
        status[14]             = overflow;
        status[15]             = empty;

        read_data = '0;
        case (wb_adr_i)
            2'd0: read_data = status;
            2'd1: read_data = empty ? 16'h0000 : head[15:0];
            2'd2: read_data = empty ? 16'h0000 : head[31:16];
            2'd3: read_data = total;
            default: read_data = '0;
        endcase
    end

    assign err_pending = ~empty;

    // Storage is not reset; only the pointers and count define its contents.
    always_ff @(posedge clk) begin
        if (!reset && push) begin
            mem[wr_ptr] <= {ts, err_we, err_type, err_addr};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ts       <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            total    <= '0;
            wb_ack_o <= 1'b0;
            wb_dat_o <= '0;
        end else begin
            ts       <= ts + 13'd1;
            wb_ack_o <= wb_req;
            wb_dat_o <= rd_req ? read_data : '0;

            if (flush) begin
                // Flush discards everything queued; a same-cycle push survives as the only entry.
                rd_ptr <= wr_ptr;
                wr_ptr <= wr_ptr + DEPTH_LOG2'(push);
                count  <= (DEPTH_LOG2 + 1)'(push);
            end else begin
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop)  rd_ptr <= rd_ptr + 1'b1;
                case ({push, pop})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
            end

            // Setting wins over a same-cycle clear.
            if (drop) begin
                overflow <= 1'b1;
            end else if (wr_req && wb_adr_i == 2'd0) begin
                overflow <= 1'b0;
            end

            if (err_strb) begin
                if (wr_req && wb_adr_i == 2'd3) begin
                    total <= 16'd1;
                end else if (total != 16'hFFFF) begin
                    total <= total + 16'd1;
                end
            end else if (wr_req && wb_adr_i == 2'd3) begin
                total <= '0;
            end
        end
    end

endmodule

// File: tb/tb_bus_error_log.sv
module tb_bus_error_log;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        err_strb = 1'b0;
    logic [1:0]  err_type = '0;
    logic        err_we = 1'b0;
    logic [15:0] err_addr = '0;
    logic        wb_cyc_i = 1'b0;
    logic        wb_stb_i = 1'b0;
    logic        wb_we_i = 1'b0;
    logic [1:0]  wb_adr_i = '0;
    logic [15:0] wb_dat_i = '0;
    logic [15:0] wb_dat_o;
    logic        wb_ack_o;
    logic        err_pending;

    int unsigned checks = 0;
    int unsigned errors = 0;

    typedef struct {
        bit          rd;
        bit          chk;
        logic [15:0] data;
        string       name;
    } exp_t;

    exp_t sb[$];

    bus_error_log #(.DEPTH_LOG2(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .err_strb   (err_strb),
        .err_type   (err_type),
        .err_we     (err_we),
        .err_addr   (err_addr),
        .wb_cyc_i   (wb_cyc_i),
        .wb_stb_i   (wb_stb_i),
        .wb_we_i    (wb_we_i),
        .wb_adr_i   (wb_adr_i),
        .wb_dat_i   (wb_dat_i),
        .wb_dat_o   (wb_dat_o),
        .wb_ack_o   (wb_ack_o),
        .err_pending(err_pending)
    );

    always #5 clk = ~clk;

    // Monitor: every ack consumes one expected transaction from the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (wb_ack_o) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_ack: ack with empty scoreboard, dat=%h", wb_dat_o);
                end else begin
                    e = sb.pop_front();
                    if (e.rd && e.chk) begin
                        checks++;
                        if (wb_dat_o !== e.data) begin
                            errors++;
                            $display("FAIL %s: got %h expected %h", e.name, wb_dat_o, e.data);
                        end
                    end
                end
            end
        end
    end

    task automatic check1(input string nm, input logic [15:0] got, input logic [15:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, got, want);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic strobe(input logic [1:0] t, input logic w, input logic [15:0] a);
        @(negedge clk);
        err_strb = 1'b1;
        err_type = t;
        err_we   = w;
        err_addr = a;
        @(negedge clk);
        err_strb = 1'b0;
    endtask

    task automatic wb(input bit we, input logic [1:0] adr, input logic [15:0] exp_d,
                      input bit chk, input string nm, input bit strb_too,
                      input logic [15:0] s_addr);
        exp_t e;
        bit   seen;
        e.rd   = !we;
        e.chk  = chk;
        e.data = exp_d;
        e.name = nm;
        sb.push_back(e);
        @(negedge clk);
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        wb_we_i  = we;
        wb_adr_i = adr;
        if (strb_too) begin
            err_strb = 1'b1;
            err_type = 2'd0;
            err_we   = 1'b0;
            err_addr = s_addr;
        end
        seen = 1'b0;
        for (int k = 0; k < 4 && !seen; k++) begin
            @(posedge clk);
            #1;
            if (wb_ack_o) seen = 1'b1;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL %s_ack_timeout: got no ack expected ack within 4 cycles", nm);
        end
        @(negedge clk);
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        wb_we_i  = 1'b0;
        err_strb = 1'b0;
        @(posedge clk);
        #1;
        check1({nm, "_ack_drop"}, {15'd0, wb_ack_o}, 16'd0);
    endtask

    task automatic rd(input logic [1:0] adr, input logic [15:0] exp_d, input string nm);
        wb(1'b0, adr, exp_d, 1'b1, nm, 1'b0, 16'h0);
    endtask

    task automatic wr(input logic [1:0] adr, input string nm);
        wb(1'b1, adr, 16'h0, 1'b0, nm, 1'b0, 16'h0);
    endtask

    initial begin
        // Reset state and single error captured at timestamp 0x0010.
        do_reset();
        check1("rst_ack", {15'd0, wb_ack_o}, 16'd0);
        check1("rst_dat", wb_dat_o, 16'h0000);
        check1("rst_pending", {15'd0, err_pending}, 16'd0);
        repeat (16) @(posedge clk);
        strobe(2'd1, 1'b1, 16'h1234);
        check1("single_pending", {15'd0, err_pending}, 16'd1);
        rd(2'd0, 16'h0001, "single_status");
        rd(2'd1, 16'h1234, "single_addr");
        rd(2'd2, 16'h0085, "single_ts_we_type");
        rd(2'd0, 16'h8000, "single_status_after_pop");

        // Overflow: 17 strobes into an empty FIFO, last one dropped.
        do_reset();
        for (int i = 0; i < 17; i++) strobe(2'd0, 1'b0, 16'(i));
        rd(2'd0, 16'h4010, "ovf_status");
        rd(2'd3, 16'h0011, "ovf_total");
        wr(2'd0, "ovf_clear");
        rd(2'd0, 16'h0010, "ovf_status_cleared");

        // Push coincident with pop while full: count stays 16, newest at tail.
        wb(1'b0, 2'd2, 16'h0, 1'b0, "full_pushpop", 1'b1, 16'hBEEF);
        rd(2'd0, 16'h0010, "full_pushpop_status");
        for (int i = 1; i < 16; i++) begin
            rd(2'd1, 16'(i), "full_drain_addr");
            wb(1'b0, 2'd2, 16'h0, 1'b0, "full_drain_pop", 1'b0, 16'h0);
        end
        rd(2'd1, 16'hBEEF, "full_tail_addr");
        wb(1'b0, 2'd2, 16'h0, 1'b0, "full_tail_pop", 1'b0, 16'h0);
        rd(2'd0, 16'h8000, "full_drained_status");

        // Pointer wrap: 20 push/pop pairs in order.
        for (int i = 0; i < 20; i++) begin
            strobe(2'd2, 1'b0, 16'h0100 + 16'(i));
            rd(2'd1, 16'h0100 + 16'(i), "wrap_addr");
            wb(1'b0, 2'd2, 16'h0, 1'b0, "wrap_pop", 1'b0, 16'h0);
        end
        rd(2'd0, 16'h8000, "wrap_final_status");

        // Flush, then empty-FIFO reads return zero and pop has no effect.
        for (int i = 0; i < 3; i++) strobe(2'd3, 1'b1, 16'hA000 + 16'(i));
        rd(2'd0, 16'h0003, "flush_pre_status");
        wr(2'd1, "flush");
        rd(2'd0, 16'h8000, "flush_status");
        rd(2'd1, 16'h0000, "empty_addr");
        rd(2'd2, 16'h0000, "empty_pop");
        rd(2'd0, 16'h8000, "empty_pop_status");
        check1("empty_pending", {15'd0, err_pending}, 16'd0);

        // Total counter saturation and clear colliding with a strobe.
        do_reset();
        @(negedge clk);
        err_strb = 1'b1;
        err_addr = 16'h5555;
        repeat (65536) @(posedge clk);
        @(negedge clk);
        err_strb = 1'b0;
        rd(2'd3, 16'hFFFF, "sat_total");
        wb(1'b1, 2'd3, 16'h0, 1'b0, "sat_clear", 1'b1, 16'h7777);
        rd(2'd3, 16'h0001, "sat_clear_with_strb");

        // Reset mid-operation; a strobe during the reset cycle is ignored.
        do_reset();
        for (int i = 0; i < 5; i++) strobe(2'd1, 1'b0, 16'h0200 + 16'(i));
        check1("mid_pending_before", {15'd0, err_pending}, 16'd1);
        rd(2'd0, 16'h0005, "mid_status_before");
        @(negedge clk);
        reset    = 1'b1;
        err_strb = 1'b1;
        @(negedge clk);
        reset    = 1'b0;
        err_strb = 1'b0;
        check1("mid_pending_after", {15'd0, err_pending}, 16'd0);
        rd(2'd0, 16'h8000, "mid_status_after");
        rd(2'd3, 16'h0000, "mid_total_after");

        repeat (3) @(posedge clk);
        check1("scoreboard_drained", 16'(sb.size()), 16'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
